// File: rtl/lut_config_loader_pkg.sv
// Shared types and sizing helpers for the serial LUT configuration loader.
// Optional parity support is enabled with LUT_CFG_PARITY_EN.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

  // A frame holds two truth tables of 2**inputs bits each, plus the split bit.
  function automatic int cfg_width(input int inputs);
    return 2 * (2 ** inputs) + 1;
  endfunction

  function automatic int cnt_width(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/lut_config_loader_if.sv
// Serial handshake input and committed-frame output of the LUT configuration loader.
// The parity_err signal exists only when LUT_CFG_PARITY_EN is defined.
interface lut_config_loader_if #(
  parameter int INPUTS = 4
) ();

  localparam int CFG_WIDTH = lut_cfg_pkg::cfg_width(INPUTS);

  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 abort;
  logic [CFG_WIDTH-1:0] config_out;
  logic                 cen;
  logic                 busy;
`ifdef LUT_CFG_PARITY_EN
  logic                 parity_err;

  modport master (
    output bit_in, bit_valid, abort,
    input  bit_ready, config_out, cen, busy, parity_err
  );

  modport slave (
    input  bit_in, bit_valid, abort,
    output bit_ready, config_out, cen, busy, parity_err
  );
`else
  modport master (
    output bit_in, bit_valid, abort,
    input  bit_ready, config_out, cen, busy
  );

  modport slave (
    input  bit_in, bit_valid, abort,
    output bit_ready, config_out, cen, busy
  );
`endif

endinterface

// File: rtl/lut_config_loader.sv
// Assembles an MSB-first serial frame and commits it to the dual-LUT with a one-cycle cen.
// Define LUT_CFG_PARITY_EN to require a trailing even-parity bit per frame.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS = 4
) (
  input logic               cclk,
  input logic               rst,
  lut_config_loader_if.slave cfg
);

  localparam int CFG_WIDTH = cfg_width(INPUTS);
  localparam int CNT_W     = cnt_width(CFG_WIDTH);

  cfg_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CFG_WIDTH-1:0] config_q, config_d;
  logic                 cen_q, cen_d;
  logic [CFG_WIDTH-1:0] shifted;
  logic                 accept;
  logic                 frame_done;
`ifdef LUT_CFG_PARITY_EN
  logic                 parity_q, parity_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // abort takes priority over a bit presented in the same cycle
  assign accept     = cfg.bit_valid && (state_q != COMMIT) && !cfg.abort;
  assign shifted    = {shadow_q[CFG_WIDTH-2:0], cfg.bit_in};
  assign frame_done = (count_q == CNT_W'(CFG_WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    config_d = config_q;
    cen_d    = 1'b0;
`ifdef LUT_CFG_PARITY_EN
    parity_d     = parity_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d = shifted;
          count_d  = CNT_W'(1);
          state_d  = SHIFT;
`ifdef LUT_CFG_PARITY_EN
          parity_d = cfg.bit_in;
`endif
        end
      end
      SHIFT: begin
        if (cfg.abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (accept) begin
          shadow_d = shifted;
          count_d  = count_q + CNT_W'(1);
`ifdef LUT_CFG_PARITY_EN
          parity_d = parity_q ^ cfg.bit_in;
          if (frame_done) state_d = PARITY;
`else
          // config_out and cen are registered on entry so they are valid during COMMIT
          if (frame_done) begin
            state_d  = COMMIT;
            config_d = shifted;
            cen_d    = 1'b1;
          end
`endif
        end
      end
      PARITY: begin
`ifdef LUT_CFG_PARITY_EN
        if (cfg.abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (accept) begin
          if (parity_q ^ cfg.bit_in) begin
            state_d      = IDLE;
            count_d      = '0;
            parity_err_d = 1'b1;
          end else begin
            state_d  = COMMIT;
            config_d = shadow_q;
            cen_d    = 1'b1;
          end
        end
`else
        state_d = IDLE;
        count_d = '0;
`endif
      end
      COMMIT: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      config_q <= '0;
      cen_q    <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      config_q <= config_d;
      cen_q    <= cen_d;
`ifdef LUT_CFG_PARITY_EN
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign cfg.bit_ready  = (state_q != COMMIT);
  assign cfg.busy       = (state_q != IDLE);
  assign cfg.config_out = config_q;
  assign cfg.cen        = cen_q;
`ifdef LUT_CFG_PARITY_EN
  assign cfg.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader at INPUTS=2 (9-bit frames); parity cases run
// when LUT_CFG_PARITY_EN is defined.
module tb_lut_config_loader;

  localparam int INPUTS = 2;
`ifdef LUT_CFG_PARITY_EN
  localparam int FRAME_GAP = 11;
`else
  localparam int FRAME_GAP = 10;
`endif

  logic cclk = 1'b0;
  logic rst;

  int checks         = 0;
  int failures       = 0;
  int cycle          = 0;
  int cen_seen       = 0;
  int last_cen_cycle = 0;
  int first_cen      = 0;
  int cen_before     = 0;

  always #5 cclk = ~cclk;

  lut_config_loader_if #(.INPUTS(INPUTS)) cfg_bus ();

  lut_config_loader #(.INPUTS(INPUTS)) dut (
    .cclk (cclk),
    .rst  (rst),
    .cfg  (cfg_bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs are driven at the falling edge, so outputs are sampled half a cycle after each rising edge.
  task automatic applyStimulus(input logic b, input logic v, input logic a);
    cfg_bus.bit_in    = b;
    cfg_bus.bit_valid = v;
    cfg_bus.abort     = a;
    @(negedge cclk);
    cycle++;
    if (cfg_bus.cen === 1'b1) begin
      cen_seen++;
      last_cen_cycle = cycle;
    end
  endtask

  task automatic send_bit(input logic b, input bit toggle);
    logic was_ready;
    bit   done;
    done = 1'b0;
    if (toggle) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4 && !done; i++) begin
      was_ready = cfg_bus.bit_ready;
      applyStimulus(b, 1'b1, 1'b0);
      done = (was_ready === 1'b1);
    end
    if (!done) checkOutput("bit_accept", {31'b0, done}, 32'd1);
  endtask

  task automatic send_raw(input logic [8:0] f, input bit toggle);
    for (int i = 8; i >= 0; i--) send_bit(f[i], toggle && (i != 8));
  endtask

  task automatic send_frame(input logic [8:0] f, input bit toggle);
    send_raw(f, toggle);
`ifdef LUT_CFG_PARITY_EN
    send_bit(^f, toggle);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    cfg_bus.bit_in    = 1'b0;
    cfg_bus.bit_valid = 1'b0;
    cfg_bus.abort     = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_config", 32'(cfg_bus.config_out), 32'h000);
    checkOutput("rst_cen", 32'(cfg_bus.cen), 32'd0);
    checkOutput("rst_busy", 32'(cfg_bus.busy), 32'd0);
    checkOutput("rst_ready", 32'(cfg_bus.bit_ready), 32'd1);
`ifdef LUT_CFG_PARITY_EN
    checkOutput("rst_parity_err", 32'(cfg_bus.parity_err), 32'd0);
`endif
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Frame 1,0,1,1,0,1,0,0,1 with valid held high
    cen_before = cen_seen;
    send_frame(9'h169, 1'b0);
    checkOutput("t1_cen", 32'(cfg_bus.cen), 32'd1);
    checkOutput("t1_config", 32'(cfg_bus.config_out), 32'h169);
    checkOutput("t1_ready_commit", 32'(cfg_bus.bit_ready), 32'd0);
    checkOutput("t1_busy_commit", 32'(cfg_bus.busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_cen_low", 32'(cfg_bus.cen), 32'd0);
    checkOutput("t1_ready_after", 32'(cfg_bus.bit_ready), 32'd1);
    checkOutput("t1_busy_after", 32'(cfg_bus.busy), 32'd0);
    checkOutput("t1_pulses", 32'(cen_seen - cen_before), 32'd1);

    // Same frame with valid toggling
    cen_before = cen_seen;
    send_frame(9'h169, 1'b1);
    checkOutput("t2_cen", 32'(cfg_bus.cen), 32'd1);
    checkOutput("t2_config", 32'(cfg_bus.config_out), 32'h169);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t2_pulses", 32'(cen_seen - cen_before), 32'd1);

    // Abort in IDLE with a valid bit, then abort on the 6th bit of a frame
    cen_before = cen_seen;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t3_idle_abort_busy", 32'(cfg_bus.busy), 32'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    checkOutput("t3_busy_mid", 32'(cfg_bus.busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t3_busy_abort", 32'(cfg_bus.busy), 32'd0);
    checkOutput("t3_cen_abort", 32'(cfg_bus.cen), 32'd0);
    checkOutput("t3_config_kept", 32'(cfg_bus.config_out), 32'h169);
    checkOutput("t3_no_pulse", 32'(cen_seen - cen_before), 32'd0);
    send_frame(9'h0FF, 1'b0);
    checkOutput("t3_cen_fresh", 32'(cfg_bus.cen), 32'd1);
    checkOutput("t3_config_fresh", 32'(cfg_bus.config_out), 32'h0FF);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset on the cycle the 9th bit is accepted
    cen_before = cen_seen;
    for (int i = 8; i >= 1; i--) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_cen", 32'(cfg_bus.cen), 32'd0);
    checkOutput("t4_config", 32'(cfg_bus.config_out), 32'h000);
    checkOutput("t4_busy", 32'(cfg_bus.busy), 32'd0);
    checkOutput("t4_ready", 32'(cfg_bus.bit_ready), 32'd1);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4_no_pulse", 32'(cen_seen - cen_before), 32'd0);

    // Back-to-back frames with valid held high
    send_frame(9'h1AA, 1'b0);
    checkOutput("t5_cen_a", 32'(cfg_bus.cen), 32'd1);
    checkOutput("t5_config_a", 32'(cfg_bus.config_out), 32'h1AA);
    first_cen = last_cen_cycle;
    send_frame(9'h055, 1'b0);
    checkOutput("t5_cen_b", 32'(cfg_bus.cen), 32'd1);
    checkOutput("t5_config_b", 32'(cfg_bus.config_out), 32'h055);
    checkOutput("t5_gap", 32'(last_cen_cycle - first_cen), 32'(FRAME_GAP));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_cen_low", 32'(cfg_bus.cen), 32'd0);

`ifdef LUT_CFG_PARITY_EN
    // Good parity commits, bad parity is dropped and flags a sticky error
    send_raw(9'h169, 1'b0);
    send_bit(1'b1, 1'b0);
    checkOutput("t6_good_cen", 32'(cfg_bus.cen), 32'd1);
    checkOutput("t6_good_config", 32'(cfg_bus.config_out), 32'h169);
    checkOutput("t6_good_err", 32'(cfg_bus.parity_err), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    send_raw(9'h0FF, 1'b0);
    send_bit(1'b0, 1'b0);
    checkOutput("t6_even_config", 32'(cfg_bus.config_out), 32'h0FF);
    applyStimulus(1'b0, 1'b0, 1'b0);
    cen_before = cen_seen;
    send_raw(9'h169, 1'b0);
    send_bit(1'b0, 1'b0);
    checkOutput("t6_bad_cen", 32'(cfg_bus.cen), 32'd0);
    checkOutput("t6_bad_err", 32'(cfg_bus.parity_err), 32'd1);
    checkOutput("t6_bad_busy", 32'(cfg_bus.busy), 32'd0);
    checkOutput("t6_bad_config", 32'(cfg_bus.config_out), 32'h0FF);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t6_err_sticky", 32'(cfg_bus.parity_err), 32'd1);
    checkOutput("t6_no_pulse", 32'(cen_seen - cen_before), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t6_err_cleared", 32'(cfg_bus.parity_err), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
